// File: rtl/sort_frame_serializer.sv
// sort_frame_serializer: buffers one sorted frame per handshake and streams its
// elements out one per beat (index 0 first) with index/last markers. An optional
// checker flags any accepted frame that is not non-increasing in a sticky bit.
module sort_frame_serializer #(
  parameter int DATA_N   = 4,
  parameter int DATA_W   = 4,
  parameter int CHECK_EN = 1,
  localparam int IDX_W   = (DATA_N > 1) ? $clog2(DATA_N) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  input  logic [DATA_N-1:0][DATA_W-1:0]  frame_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last,
  output logic                           order_err,
  input  logic                           err_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d, idx_nxt;
  logic [DATA_N-1:0][DATA_W-1:0]   frame_buf_q, frame_buf_d;
  logic                            out_valid_q, out_valid_d;
  logic [DATA_W-1:0]               out_data_q, out_data_d;
  logic [IDX_W-1:0]                out_idx_q, out_idx_d;
  logic                            out_last_q, out_last_d;
  logic                            order_err_q, order_err_d;
  logic                            accept, beat, viol;

  // Handshakes and next-state for the streaming path; an accept on the final
  // beat reloads element 0 directly so back-to-back frames have no bubble.
  always_comb begin
    frame_ready = !rst && (state_q == IDLE || (out_valid_q && out_ready && out_last_q));
    accept      = frame_valid && frame_ready;
    beat        = out_valid_q && out_ready;
    idx_nxt     = idx_q + 1'b1;

    state_d     = state_q;
    idx_d       = idx_q;
    frame_buf_d = frame_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    if (accept) begin
      state_d     = SEND;
      frame_buf_d = frame_data;
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = frame_data[0];
      out_idx_d   = '0;
      out_last_d  = (DATA_N == 1);
    end else if (beat) begin
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end else begin
        idx_d       = idx_nxt;
        out_data_d  = frame_buf_q[idx_nxt];
        out_idx_d   = idx_nxt;
        out_last_d  = (idx_nxt == LAST_IDX);
      end
    end
  end

  // Order checker: a new violation wins over a simultaneous clear.
  always_comb begin
    viol = 1'b0;
    if (CHECK_EN != 0) begin
      for (int unsigned i = 0; i + 1 < unsigned'(DATA_N); i++) begin
        if (frame_data[IDX_W'(i + 1)] > frame_data[IDX_W'(i)]) viol = 1'b1;
      end
    end
    order_err_d = order_err_q;
    if (err_clr)         order_err_d = 1'b0;
    if (accept && viol)  order_err_d = 1'b1;
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_buf_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_buf_q <= frame_buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      order_err_q <= order_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign order_err = order_err_q;

endmodule

// File: tb/tb_sort_frame_serializer.sv
// Scoreboard bench for sort_frame_serializer (DATA_N=4, DATA_W=4).
module tb_sort_frame_serializer;

  localparam int N = 4;
  localparam int W = 4;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_valid = 1'b0;
  logic         frame_ready;
  frame_t       frame_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         order_err;
  logic         err_clr = 1'b0;

  int    checks = 0;
  int    errors = 0;
  bit    rand_rdy = 0;

  // reference model state
  beat_t sbq[$];
  beat_t hold = '0;
  beat_t cur;
  bit    m_err = 0;
  bit    exp_valid, exp_ready, m_accept, m_viol;

  sort_frame_serializer #(.DATA_N(N), .DATA_W(W), .CHECK_EN(1)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .order_err(order_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = 4'(a); f[1] = 4'(b); f[2] = 4'(c); f[3] = 4'(d);
    return f;
  endfunction

  // Monitor: compare DUT against the model, then advance the model using the
  // inputs that will be sampled at the coming posedge.
  always @(negedge clk) begin
    exp_valid = (sbq.size() > 0);
    exp_ready = !rst && (sbq.size() == 0 || (sbq.size() == 1 && out_ready));
    chk("frame_ready", 32'(frame_ready), 32'(exp_ready));
    chk("out_valid",   32'(out_valid),   32'(exp_valid));
    chk("order_err",   32'(order_err),   32'(m_err));
    cur = exp_valid ? sbq[0] : hold;
    chk("out_data", 32'(out_data), 32'(cur.data));
    chk("out_idx",  32'(out_idx),  32'(cur.idx));
    chk("out_last", 32'(out_last), 32'(cur.last));

    if (rst) begin
      sbq.delete();
      hold  = '0;
      m_err = 0;
    end else begin
      m_accept = frame_valid && exp_ready;
      if (exp_valid && out_ready) hold = sbq.pop_front();
      m_viol = 0;
      if (m_accept) begin
        for (int i = 0; i < N; i++) begin
          sbq.push_back('{data: frame_data[i], idx: 2'(i), last: (i == N - 1)});
          if (i > 0 && frame_data[i] > frame_data[i-1]) m_viol = 1;
        end
      end
      if (m_accept && m_viol) m_err = 1;
      else if (err_clr)       m_err = 0;
    end
  end

  // Optional random backpressure.
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_frame(input frame_t f);
    bit acc = 0;
    int n = 0;
    frame_valid = 1'b1;
    frame_data  = f;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = frame_ready;
      n++;
      @(posedge clk); #1;
    end
    frame_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout at %0t: got no accept expected accept within 64 cycles", $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    frame_t rf;
    int q[$];

    // 1: reset with a frame offered
    frame_valid = 1'b1;
    frame_data  = mk(9, 7, 3, 1);
    idle(2);
    rst = 1'b0;
    frame_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // 2: single frame
    send_frame(mk(9, 7, 3, 1));
    idle(6);

    // 3: back-to-back frames, equal elements are legal
    send_frame(mk(15, 8, 8, 0));
    send_frame(mk(6, 5, 4, 2));
    idle(6);

    // 4: stall at idx 1
    send_frame(mk(9, 7, 3, 1));
    idle(1);
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(6);

    // 5: order error, clear with simultaneous violation, then plain clear
    send_frame(mk(2, 5, 1, 0));
    idle(6);
    err_clr = 1'b1;
    send_frame(mk(0, 1, 0, 0));
    err_clr = 1'b0;
    idle(6);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);

    // 6: reset mid-frame
    send_frame(mk(9, 7, 3, 1));
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    send_frame(mk(8, 4, 2, 1));
    idle(6);

    // random frames with backpressure, gaps and clears
    rand_rdy = 1;
    for (int k = 0; k < 60; k++) begin
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) q.rsort();
      for (int i = 0; i < N; i++) rf[i] = 4'(q[i]);
      err_clr = ($urandom_range(0, 5) == 0);
      send_frame(rf);
      err_clr = 1'b0;
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 6)));
    end
    rand_rdy = 0;
    idle(1);
    out_ready = 1'b1;
    idle(8);
    chk("drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1);
  end

endmodule
